// File: rtl/sq_wqe_fetch_if.sv
// Doorbell, DMA request, fetch-tag and status signals of the send-queue WQE fetcher.
// slave = the fetcher's view, master = the environment's view.
interface sq_wqe_fetch_if #(
    parameter int NUM_QP = 256
);
    localparam int QPI = (NUM_QP > 1) ? $clog2(NUM_QP) : 1;

    logic             s_sq_valid;
    logic             s_sq_ready;
    logic [167:0]     s_sq_data;
    logic             m_dma_valid;
    logic             m_dma_ready;
    logic [115:0]     m_dma_data;
    logic             m_tag_valid;
    logic             m_tag_ready;
    logic [QPI-1:0]   m_tag_qp;
    logic             err_ovf;
    logic [31:0]      stat_db;
    logic [31:0]      stat_fetch;

    modport slave (
        input  s_sq_valid, s_sq_data, m_dma_ready, m_tag_ready,
        output s_sq_ready, m_dma_valid, m_dma_data, m_tag_valid, m_tag_qp,
               err_ovf, stat_db, stat_fetch
    );

    modport master (
        output s_sq_valid, s_sq_data, m_dma_ready, m_tag_ready,
        input  s_sq_ready, m_dma_valid, m_dma_data, m_tag_valid, m_tag_qp,
               err_ovf, stat_db, stat_fetch
    );
endinterface

// File: rtl/sq_wqe_fetch.sv
// Send-queue WQE fetcher: per-QP doorbell table, round-robin fetch FSM, in-order tag FIFO.
// Define SQ_FETCH_STATS_EN to build the saturating doorbell/fetch counters.
//
// state | meaning
// IDLE  | wait for a pending QP and room in the tag FIFO
// SEL   | round-robin pick, latch QP, cons and request address
// ISSUE | hold the DMA request until accepted
module sq_wqe_fetch #(
    parameter int NUM_QP    = 256,
    parameter int SQ_DEPTH  = 64,
    parameter int WQE_BYTES = 64,
    parameter int MAX_OUTST = 4
) (
    input  logic            aclk,
    input  logic            areset,
    sq_wqe_fetch_if.slave   bus
);
    localparam int QPI   = (NUM_QP > 1) ? $clog2(NUM_QP) : 1;
    localparam int SLOTW = (SQ_DEPTH > 1) ? $clog2(SQ_DEPTH) : 1;
    localparam int AW    = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    typedef enum logic [1:0] {IDLE, SEL, ISSUE} state_e;
    state_e state_q, state_d;

    logic [63:0]        base_q [NUM_QP];
    logic [31:0]        prod_q [NUM_QP];
    logic [31:0]        cons_q [NUM_QP];
    logic [NUM_QP-1:0]  pend_q;
    logic [QPI-1:0]     rr_ptr_q;
    logic [QPI-1:0]     cur_q;
    logic [31:0]        cur_cons_q;
    logic [63:0]        paddr_q;
    logic               err_q;

    logic [QPI-1:0]     tag_mem_q [MAX_OUTST];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]        cnt_q;

    logic               db_fire, dma_fire, tag_pop, fifo_full, any_pend;
    logic [QPI-1:0]     db_idx, pick;
    logic [63:0]        db_base, sel_paddr;
    logic [31:0]        db_prod, db_cons;
    logic               found;

    assign db_fire   = bus.s_sq_valid && !areset;
    assign db_idx    = bus.s_sq_data[160 +: QPI];
    assign db_base   = bus.s_sq_data[159:96];
    assign db_prod   = bus.s_sq_data[95:64];
    assign dma_fire  = (state_q == ISSUE) && bus.m_dma_ready;
    assign tag_pop   = (cnt_q != '0) && bus.m_tag_ready;
    assign fifo_full = (cnt_q == (AW+1)'(MAX_OUTST));
    assign any_pend  = |pend_q;

    // Overflow is judged against cons including a same-cycle retire on that QP.
    assign db_cons   = (dma_fire && cur_q == db_idx) ? cur_cons_q + 32'd1 : cons_q[db_idx];

    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_QP; i++) begin
            if (!found && pend_q[i] && i >= int'(rr_ptr_q)) begin
                pick  = QPI'(i);
                found = 1'b1;
            end
        end
        for (int i = 0; i < NUM_QP; i++) begin
            if (!found && pend_q[i]) begin
                pick  = QPI'(i);
                found = 1'b1;
            end
        end
    end

    assign sel_paddr = base_q[pick] + 64'(cons_q[pick][SLOTW-1:0]) * 64'(WQE_BYTES);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_pend && !fifo_full) state_d = SEL;
            SEL:     state_d = any_pend ? ISSUE : IDLE;
            ISSUE:   if (bus.m_dma_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < NUM_QP; i++) begin
                base_q[i] <= '0;
                prod_q[i] <= '0;
                cons_q[i] <= '0;
            end
            pend_q     <= '0;
            rr_ptr_q   <= '0;
            cur_q      <= '0;
            cur_cons_q <= '0;
            paddr_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            if (db_fire) begin
                base_q[db_idx] <= db_base;
                prod_q[db_idx] <= db_prod;
                if ((db_prod - db_cons) > 32'(SQ_DEPTH)) err_q <= 1'b1;
            end
            if (dma_fire) begin
                cons_q[cur_q] <= cur_cons_q + 32'd1;
                rr_ptr_q      <= (cur_q == QPI'(NUM_QP-1)) ? '0 : cur_q + 1'b1;
            end
            for (int i = 0; i < NUM_QP; i++) pend_q[i] <= (prod_q[i] != cons_q[i]);
            // Request fields are frozen here so later doorbells cannot disturb ISSUE.
            if (state_q == SEL && any_pend) begin
                cur_q      <= pick;
                cur_cons_q <= cons_q[pick];
                paddr_q    <= sel_paddr;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < MAX_OUTST; i++) tag_mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (dma_fire) begin
                tag_mem_q[wr_ptr_q] <= cur_q;
                wr_ptr_q            <= wr_ptr_q + 1'b1;
            end
            if (tag_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (dma_fire && !tag_pop)      cnt_q <= cnt_q + 1'b1;
            else if (!dma_fire && tag_pop) cnt_q <= cnt_q - 1'b1;
        end
    end

    assign bus.s_sq_ready  = !areset;
    assign bus.m_dma_valid = (state_q == ISSUE);
    assign bus.m_dma_data  = (state_q == ISSUE) ? {4'h0, 48'(WQE_BYTES), paddr_q} : '0;
    assign bus.m_tag_valid = (cnt_q != '0);
    assign bus.m_tag_qp    = tag_mem_q[rd_ptr_q];
    assign bus.err_ovf     = err_q;

`ifdef SQ_FETCH_STATS_EN
    logic [31:0] stat_db_q, stat_fetch_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            stat_db_q    <= '0;
            stat_fetch_q <= '0;
        end else begin
            if (db_fire && stat_db_q != '1)     stat_db_q    <= stat_db_q + 32'd1;
            if (dma_fire && stat_fetch_q != '1) stat_fetch_q <= stat_fetch_q + 32'd1;
        end
    end

    assign bus.stat_db    = stat_db_q;
    assign bus.stat_fetch = stat_fetch_q;
`else
    assign bus.stat_db    = '0;
    assign bus.stat_fetch = '0;
`endif
endmodule
